// File: rtl/pulse_train_generator.sv
// Pulse train generator: each accepted trigger becomes one HIGH_CYCLES-wide
// pulse followed by at least LOW_CYCLES low cycles; excess triggers are queued.
module pulse_train_generator #(
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_DEPTH  = 7,
  localparam int PW = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig_in,
  input  logic          clr_ovf,
  output logic          signal_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(PEND_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [PW-1:0] pending_q, next_pending;
  logic          overflow_q, next_overflow;
  logic          signal_q, busy_q;
  logic          start_edge;
  logic          drop;

  // The counter holds the cycles remaining in the current phase; a start
  // edge is idle or the final LOW cycle.
  assign start_edge = (state == ST_IDLE) || ((state == ST_LOW) && (cnt == '0));

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    next_state    = state;
    next_cnt      = cnt;
    next_pending  = pending_q;
    next_overflow = overflow_q;
    drop          = 1'b0;

    if (start_edge) begin
      if (pending_q != '0) begin
        next_state   = ST_HIGH;
        next_cnt     = HIGH_LOAD;
        // The queued trigger is consumed; a coincident new one takes its slot.
        next_pending = trig_in ? pending_q : pending_q - PW'(1);
      end else if (trig_in) begin
        next_state = ST_HIGH;
        next_cnt   = HIGH_LOAD;
      end else begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    end else begin
      unique case (state)
        ST_HIGH: begin
          if (cnt == '0) begin
            next_state = ST_LOW;
            next_cnt   = LOW_LOAD;
          end else begin
            next_cnt = cnt - CW'(1);
          end
        end
        ST_LOW:  next_cnt = cnt - CW'(1);
        default: next_cnt = '0;
      endcase

      if (trig_in) begin
        if (pending_q == PEND_MAX) begin
          drop = 1'b1;
        end else begin
          next_pending = pending_q + PW'(1);
        end
      end
    end

    if (drop) begin
      next_overflow = 1'b1;
    end else if (clr_ovf) begin
      next_overflow = 1'b0;
    end
  end

  // Outputs are registered from the next state so signal_out and busy come
  // straight off flops and cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      signal_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      pending_q  <= next_pending;
      overflow_q <= next_overflow;
      signal_q   <= (next_state == ST_HIGH);
      busy_q     <= (next_state != ST_IDLE);
    end
  end

  assign signal_out = signal_q;
  assign busy       = busy_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: directed scenarios plus
// random traffic compared against a slot-timing reference model.
module tb_pulse_train_generator;

  localparam int H  = 2;
  localparam int L  = 2;
  localparam int D  = 3;
  localparam int PW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig_in = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          signal_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: a pulse "slot" is H+L cycles long; mdl_t is the cycle
  // index inside the slot currently being emitted.
  bit mdl_active = 0;
  int mdl_t      = 0;
  int mdl_pend   = 0;
  bit mdl_ovf    = 0;

  // Loopback edge detector and low-gap tracking on signal_out.
  bit prev_sig   = 0;
  bit seen_pulse = 0;
  int rise_cnt   = 0;
  int low_run    = 0;
  int min_gap    = 1000;

  pulse_train_generator #(
    .HIGH_CYCLES(H),
    .LOW_CYCLES (L),
    .PEND_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trig_in   (trig_in),
    .clr_ovf   (clr_ovf),
    .signal_out(signal_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mdl_active = 0;
    mdl_t      = 0;
    mdl_pend   = 0;
    mdl_ovf    = 0;
    prev_sig   = 0;
    seen_pulse = 0;
    low_run    = 0;
  endtask

  task automatic model_step(input bit trig, input bit clr);
    bit start;
    bit dropped;
    start   = !mdl_active || (mdl_t == H + L - 1);
    dropped = 0;
    if (start) begin
      if (mdl_pend > 0) begin
        mdl_active = 1;
        mdl_t      = 0;
        mdl_pend   = mdl_pend - 1 + int'(trig);
      end else if (trig) begin
        mdl_active = 1;
        mdl_t      = 0;
      end else begin
        mdl_active = 0;
        mdl_t      = 0;
      end
    end else begin
      mdl_t++;
      if (trig) begin
        if (mdl_pend < D) mdl_pend++;
        else dropped = 1;
      end
    end
    if (dropped) mdl_ovf = 1;
    else if (clr) mdl_ovf = 0;
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, then compare all outputs 1 ns later.
  task automatic tick(input bit trig, input bit clr);
    bit exp_sig;
    @(negedge clk);
    trig_in = trig;
    clr_ovf = clr;
    @(posedge clk);
    #1;
    model_step(trig, clr);
    exp_sig = mdl_active && (mdl_t < H);
    checks++;
    if (signal_out !== exp_sig) begin
      errors++;
      $display("FAIL model_signal_out t=%0t got %b exp %b", $time, signal_out, exp_sig);
    end
    checks++;
    if (busy !== mdl_active) begin
      errors++;
      $display("FAIL model_busy t=%0t got %b exp %b", $time, busy, mdl_active);
    end
    checks++;
    if (pending !== PW'(mdl_pend)) begin
      errors++;
      $display("FAIL model_pending t=%0t got %0d exp %0d", $time, pending, mdl_pend);
    end
    checks++;
    if (overflow !== mdl_ovf) begin
      errors++;
      $display("FAIL model_overflow t=%0t got %b exp %b", $time, overflow, mdl_ovf);
    end
    if (signal_out === 1'b1 && !prev_sig) begin
      rise_cnt++;
      if (seen_pulse && low_run < min_gap) min_gap = low_run;
      seen_pulse = 1;
    end
    if (signal_out === 1'b1) low_run = 0;
    else low_run++;
    prev_sig = (signal_out === 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (mdl_active && n < 200) begin
      tick(0, 0);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain_timeout got %0d cycles exp <200", name, n);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({signal_out, busy, pending, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {signal_out, busy, pending, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    bit exp_sig [5] = '{1, 1, 0, 0, 0};
    bit exp_busy[5] = '{1, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      tick(i == 0, 0);
      checks++;
      if (signal_out !== exp_sig[i] || busy !== exp_busy[i] || pending !== '0) begin
        errors++;
        $display("FAIL single_edge%0d got sig=%b busy=%b pend=%0d exp sig=%b busy=%b pend=0",
                 i, signal_out, busy, pending, exp_sig[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_burst3();
    int peak = 0;
    int rises[$];
    bit prev = 0;
    for (int i = 0; i < 13; i++) begin
      tick(i < 3, 0);
      if (int'(pending) > peak) peak = int'(pending);
      if (signal_out === 1'b1 && !prev) rises.push_back(i);
      prev = (signal_out === 1'b1);
    end
    checks++;
    if (peak != 2) begin
      errors++;
      $display("FAIL burst3_peak got %0d exp 2", peak);
    end
    checks++;
    if (rises.size() != 3 || rises[0] != 0 || rises[1] != 4 || rises[2] != 8) begin
      errors++;
      $display("FAIL burst3_rises got %p exp '{0,4,8}", rises);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL burst3_busy_end got %b exp 0", busy);
    end
  endtask

  task automatic test_overflow();
    int r0 = rise_cnt;
    for (int i = 0; i < 6; i++) begin
      tick(1, 0);
      if (i == 3 || i == 4) begin
        checks++;
        if (pending !== PW'(3)) begin
          errors++;
          $display("FAIL ovf_pending_edge%0d got %0d exp 3", i, pending);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b exp 1", overflow);
    end
    drain("ovf");
    checks++;
    if (rise_cnt - r0 != 5) begin
      errors++;
      $display("FAIL ovf_pulses got %0d exp 5", rise_cnt - r0);
    end
  endtask

  task automatic test_clr_ovf();
    tick(0, 1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_ovf_clear got %b exp 0", overflow);
    end
    for (int i = 0; i < 5; i++) tick(1, 0);
    tick(1, 1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL clr_ovf_drop_priority got %b exp 1", overflow);
    end
    drain("clr");
    tick(0, 1);
  endtask

  task automatic test_reset_mid_pulse();
    int r0;
    for (int i = 0; i < 6; i++) tick(i < 4, 0);
    checks++;
    if (signal_out !== 1'b1 || pending !== PW'(2)) begin
      errors++;
      $display("FAIL rst_setup got sig=%b pend=%0d exp sig=1 pend=2", signal_out, pending);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (signal_out !== 1'b0 || busy !== 1'b0 || pending !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got sig=%b busy=%b pend=%0d ovf=%b exp all 0",
               signal_out, busy, pending, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    r0 = rise_cnt;
    tick(1, 0);
    checks++;
    if (signal_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_trigger got %b exp 1", signal_out);
    end
    drain("rst");
    checks++;
    if (rise_cnt - r0 != 1) begin
      errors++;
      $display("FAIL rst_pulses got %0d exp 1", rise_cnt - r0);
    end
  endtask

  task automatic test_loopback();
    int r0 = rise_cnt;
    int sent = 0;
    min_gap    = 1000;
    seen_pulse = 0;
    while (sent < 20) begin
      if (mdl_pend < D) begin
        tick(1, 0);
        sent++;
      end else begin
        tick(0, 0);
      end
      repeat ($urandom_range(0, 5)) tick(0, 0);
    end
    drain("loop");
    checks++;
    if (rise_cnt - r0 != 20) begin
      errors++;
      $display("FAIL loop_edges got %0d exp 20", rise_cnt - r0);
    end
    checks++;
    if (min_gap < L) begin
      errors++;
      $display("FAIL loop_min_gap got %0d exp >=%0d", min_gap, L);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL loop_overflow got %b exp 0", overflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 10);
    end
    drain("rand");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst3();
    test_overflow();
    test_clr_ovf();
    test_reset_mid_pulse();
    test_loopback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
